// File: rtl/prm_edge_scan_seq.sv
// rtl/prm_edge_scan_seq.sv - edge-code scan sequencer feeding the PRM obstacle checkers, packing edge_mask results into words
// Optional blocked-edge statistics counter is enabled by defining PRM_SCAN_STATS_EN.
module prm_edge_scan_seq #(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [14:0]       base_code,
  input  logic [CNT_W-1:0]  count,
  output logic [14:0]       chk_code,
  input  logic              chk_mask,
  output logic [WORD_W-1:0] res_word,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  blocked_cnt
);

  localparam int IDX_W = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  remaining;
  logic [IDX_W-1:0]  bit_idx;
  logic [WORD_W-1:0] pack;

  logic ev;
  logic eval_en;
  logic handshake;
  logic last_code;
  logic word_done;
  logic start_go;
  logic start_any;

  // A code is evaluated only when its word has somewhere to go.
  always_comb begin
    ev        = !res_valid || res_ready;
    handshake = res_valid && res_ready;
    eval_en   = (state == ST_SCAN) && ev;
    last_code = (remaining == CNT_W'(1));
    word_done = eval_en && ((bit_idx == IDX_W'(WORD_W - 1)) || last_code);
    start_any = (state == ST_IDLE) && start;
    start_go  = start_any && (count != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    case (state)
      ST_IDLE:  if (start) state_nxt = (count == '0) ? ST_DONE : ST_SCAN;
      ST_SCAN:  if (word_done && last_code) state_nxt = ST_DRAIN;
      ST_DRAIN: if (handshake) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chk_code  <= '0;
      remaining <= '0;
      bit_idx   <= '0;
      pack      <= '0;
      res_word  <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
    end else begin
      if (start_go) begin
        chk_code  <= base_code;
        remaining <= count;
        bit_idx   <= '0;
        pack      <= '0;
      end else if (eval_en) begin
        chk_code  <= chk_code + 15'd1;
        remaining <= remaining - CNT_W'(1);
        if (word_done) begin
          bit_idx <= '0;
          pack    <= '0;
        end else begin
          bit_idx       <= bit_idx + IDX_W'(1);
          pack[bit_idx] <= chk_mask;
        end
      end

      // A word loading on the same edge as a handshake keeps res_valid high.
      if (word_done) begin
        res_word  <= pack | ({{(WORD_W-1){1'b0}}, chk_mask} << bit_idx);
        res_valid <= 1'b1;
        res_last  <= last_code;
      end else if (handshake) begin
        res_valid <= 1'b0;
        res_last  <= 1'b0;
      end
    end
  end

`ifdef PRM_SCAN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blocked_cnt <= '0;
    end else if (start_any) begin
      blocked_cnt <= '0;
    end else if (eval_en && chk_mask && (blocked_cnt != '1)) begin
      blocked_cnt <= blocked_cnt + CNT_W'(1);
    end
  end
`else
  assign blocked_cnt = '0;
`endif

endmodule
